// File: rtl/alu_result_stage_pkg.sv
// Shared types and the flag computation for the ALU result stage.
// The flag function is kept here so any stage consuming ALU lanes derives N/Z/C/V the same way.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ASL = 2'd2,
    OP_ASR = 2'd3
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } skid_state_t;

  localparam int FLAGS_W = 4;

  // Shifts leave C and V untouched, so the current architectural values flow through.
  function automatic alu_flags_t calc_flags(
    input alu_op_t    op,
    input logic       sel_msb,
    input logic       sel_zero,
    input logic       a_msb,
    input logic       b_msb,
    input logic       sum_msb,
    input logic       carry,
    input alu_flags_t cur
  );
    alu_flags_t f;
    f.n = sel_msb;
    f.z = sel_zero;
    f.c = cur.c;
    f.v = cur.v;
    case (op)
      OP_ADD: begin
        f.c = carry;
        f.v = (a_msb == b_msb) & (sum_msb != a_msb);
      end
      OP_SUB: begin
        f.c = carry;
        f.v = (a_msb != b_msb) & (sum_msb != a_msb);
      end
      default: begin
        f.c = cur.c;
        f.v = cur.v;
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-to-writeback bundle: input handshake with operand/result lanes, output handshake with flags.
// master is the surrounding pipeline (ALU + writeback), slave is the result stage.
interface alu_result_stage_if #(
  parameter int N     = 4,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op_sel;
  logic             set_flags;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [N-1:0]     d0;
  logic [N-1:0]     d1;
  logic [N-1:0]     d2;
  logic [N-1:0]     d3;
  logic             carry_out;
  logic             msb_result;
  logic [TAG_W-1:0] tag_in;

  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic [TAG_W-1:0] tag_out;
  logic [3:0]       flags_out;
  logic [3:0]       flags_reg;

  modport master (
    output in_valid, op_sel, set_flags, a, b, d0, d1, d2, d3,
           carry_out, msb_result, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out, flags_out, flags_reg
  );

  modport slave (
    input  in_valid, op_sel, set_flags, a, b, d0, d1, d2, d3,
           carry_out, msb_result, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, flags_out, flags_reg
  );

endinterface

// File: rtl/alu_result_stage_skid_buffer.sv
// Generic two-entry valid/ready buffer; MAIN drives the outputs, SKID absorbs one beat of stall.
// in_ready and out_valid both come straight from flops so neither side sees a comb path through.
module alu_skid_buffer
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  // Occupancy transitions and entry moves.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SB_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data_i;
          state_d = SB_ONE;
        end else begin
          state_d = SB_EMPTY;
        end
      end
      SB_ONE: begin
        if (in_fire && !out_fire) begin
          skid_d  = in_data_i;
          state_d = SB_FULL;
        end else if (in_fire && out_fire) begin
          main_d  = in_data_i;
          state_d = SB_ONE;
        end else if (out_fire) begin
          state_d = SB_EMPTY;
        end else begin
          state_d = SB_ONE;
        end
      end
      SB_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = SB_ONE;
        end else begin
          state_d = SB_FULL;
        end
      end
      default: begin
        state_d = SB_EMPTY;
      end
    endcase
    in_ready_d  = (state_d != SB_FULL);
    out_valid_d = (state_d != SB_EMPTY);
  end

  // State and entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SB_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: lane select, N/Z/C/V, architectural flag register,
// and a skid-buffered handshake to writeback.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_stage_if.slave bus
);

  localparam int W = N + TAG_W + FLAGS_W;

  alu_op_t          op;
  logic [N-1:0]     sel;
  alu_flags_t       flags_new;
  alu_flags_t       flags_q, flags_d;
  logic             in_ready;
  logic             in_fire;
  logic             out_valid;
  logic [W-1:0]     in_word;
  logic [W-1:0]     out_word;

  assign op = alu_op_t'(bus.op_sel);

  // Result lane select.
  always_comb begin
    sel = bus.d0;
    case (op)
      OP_ADD:  sel = bus.d0;
      OP_SUB:  sel = bus.d1;
      OP_ASL:  sel = bus.d2;
      OP_ASR:  sel = bus.d3;
      default: sel = bus.d0;
    endcase
  end

  assign flags_new = calc_flags(op, sel[N-1], (sel == {N{1'b0}}),
                                bus.a[N-1], bus.b[N-1], bus.msb_result,
                                bus.carry_out, flags_q);

  assign in_fire = bus.in_valid & in_ready;

  // Flags commit in program order at accept, so a stalled writeback never delays them.
  always_comb begin
    flags_d = flags_q;
    if (in_fire && bus.set_flags) begin
      flags_d = flags_new;
    end else begin
      flags_d = flags_q;
    end
  end

  // Architectural flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign in_word = {sel, bus.tag_in, flags_new};

  alu_skid_buffer #(
    .W (W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_word),
    .out_valid_o (out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_word)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = out_word[W-1 -: N];
  assign bus.tag_out   = out_word[FLAGS_W +: TAG_W];
  assign bus.flags_out = out_word[FLAGS_W-1:0];
  assign bus.flags_reg = flags_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (N=4): a negedge scoreboard tracks occupancy, flags_reg
// and in-order results, while the main sequence adds spot checks at the points of interest.
module tb_alu_result_stage;

  localparam int N     = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [3:0] res;
    logic [3:0] tag;
    logic [3:0] flg;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_result_stage_if #(.N(N), .TAG_W(TAG_W)) bus ();

  alu_result_stage #(.N(N), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       sb_q[$];
  logic [3:0] mdl_flags = 4'h0;
  int         n_checks  = 0;
  int         n_fails   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_sel(input logic [1:0] op, input logic [3:0] d0, d1, d2, d3);
    case (op)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic [3:0] model_flags(input logic [1:0] op, input logic [3:0] s,
                                             input logic [3:0] a, b, input logic co, ms,
                                             input logic [3:0] cur);
    logic c;
    logic v;
    c = cur[1];
    v = cur[0];
    if (op == 2'd0) begin
      c = co;
      v = (a[3] == b[3]) && (ms != a[3]);
    end else if (op == 2'd1) begin
      c = co;
      v = (a[3] != b[3]) && (ms != a[3]);
    end
    return {s[3], (s == 4'd0), c, v};
  endfunction

  // Scoreboard: occupancy, flag register and head-of-queue checks, then pop/push for the coming edge.
  always @(negedge clk) begin
    int   occ;
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      mdl_flags = 4'h0;
    end else begin
      occ = sb_q.size();
      chk("sb_in_ready", {31'd0, bus.in_ready}, {31'd0, (occ < 2)});
      chk("sb_out_valid", {31'd0, bus.out_valid}, {31'd0, (occ != 0)});
      chk("sb_flags_reg", {28'd0, bus.flags_reg}, {28'd0, mdl_flags});
      if (occ != 0) begin
        chk("sb_result", {28'd0, bus.result}, {28'd0, sb_q[0].res});
        chk("sb_tag_out", {28'd0, bus.tag_out}, {28'd0, sb_q[0].tag});
        chk("sb_flags_out", {28'd0, bus.flags_out}, {28'd0, sb_q[0].flg});
        if (bus.out_ready) void'(sb_q.pop_front());
      end
      if (bus.in_valid && occ < 2) begin
        e.res = model_sel(bus.op_sel, bus.d0, bus.d1, bus.d2, bus.d3);
        e.tag = bus.tag_in;
        e.flg = model_flags(bus.op_sel, e.res, bus.a, bus.b, bus.carry_out, bus.msb_result, mdl_flags);
        sb_q.push_back(e);
        if (bus.set_flags) mdl_flags = e.flg;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic sf, input logic [3:0] tag);
    logic [4:0] sum;
    logic [4:0] dif;
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    bus.a          = a;
    bus.b          = b;
    bus.d0         = sum[3:0];
    bus.d1         = dif[3:0];
    bus.d2         = {a[2:0], 1'b0};
    bus.d3         = {a[3], a[3:1]};
    bus.carry_out  = (op == 2'd1) ? ~dif[4] : sum[4];
    bus.msb_result = (op == 2'd1) ? dif[3] : sum[3];
    bus.op_sel     = op;
    bus.set_flags  = sf;
    bus.tag_in     = tag;
    bus.in_valid   = 1'b1;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.op_sel     = 2'd0;
    bus.set_flags  = 1'b0;
    bus.a          = 4'd0;
    bus.b          = 4'd0;
    bus.d0         = 4'd0;
    bus.d1         = 4'd0;
    bus.d2         = 4'd0;
    bus.d3         = 4'd0;
    bus.carry_out  = 1'b0;
    bus.msb_result = 1'b0;
    bus.tag_in     = 4'd0;
    bus.out_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_result", {28'd0, bus.result}, 32'd0);
    chk("rst_tag_out", {28'd0, bus.tag_out}, 32'd0);
    chk("rst_flags_out", {28'd0, bus.flags_out}, 32'd0);
    chk("rst_flags_reg", {28'd0, bus.flags_reg}, 32'd0);
    rst_n = 1'b1;

    // add overflow: 7+1
    bus.out_ready = 1'b1;
    drive(2'd0, 4'd7, 4'd1, 1'b1, 4'd1);
    cyc();
    bus.in_valid = 1'b0;
    chk("t1_result", {28'd0, bus.result}, 32'd8);
    chk("t1_flags_out", {28'd0, bus.flags_out}, 32'b1001);
    chk("t1_flags_reg", {28'd0, bus.flags_reg}, 32'b1001);

    // sub to zero, then asl holding C/V
    drive(2'd1, 4'd3, 4'd3, 1'b1, 4'd2);
    cyc();
    chk("t2_sub_result", {28'd0, bus.result}, 32'd0);
    chk("t2_sub_flags", {28'd0, bus.flags_out}, 32'b0110);
    drive(2'd2, 4'd2, 4'd0, 1'b1, 4'd3);
    cyc();
    bus.in_valid = 1'b0;
    chk("t2_asl_result", {28'd0, bus.result}, 32'd4);
    chk("t2_asl_flags", {28'd0, bus.flags_out}, 32'b0010);
    chk("t2_asl_flags_reg", {28'd0, bus.flags_reg}, 32'b0010);
    cyc();

    // two accepts under stall fill both entries
    bus.out_ready = 1'b0;
    drive(2'd0, 4'd5, 4'd6, 1'b1, 4'd4);
    cyc();
    drive(2'd1, 4'd2, 4'd5, 1'b0, 4'd5);
    cyc();
    chk("t3_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    chk("t3_head_result", {28'd0, bus.result}, 32'hB);
    chk("t3_flags_reg", {28'd0, bus.flags_reg}, 32'b1001);

    // third item waits while full; flags untouched
    drive(2'd1, 4'd0, 4'd1, 1'b1, 4'd6);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_in_ready_held", {31'd0, bus.in_ready}, 32'd0);
      chk("t4_flags_reg_held", {28'd0, bus.flags_reg}, 32'b1001);
    end
    bus.out_ready = 1'b1;
    cyc();
    chk("t4_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    chk("t4_second_result", {28'd0, bus.result}, 32'hD);
    chk("t4_flags_before_accept", {28'd0, bus.flags_reg}, 32'b1001);
    cyc();
    bus.in_valid = 1'b0;
    chk("t4_third_result", {28'd0, bus.result}, 32'hF);
    chk("t4_flags_after_accept", {28'd0, bus.flags_reg}, 32'b1000);
    cyc();
    chk("t4_drained", {31'd0, bus.out_valid}, 32'd0);

    // streaming: accept and emit every cycle
    for (int i = 0; i < 10; i++) begin
      drive(2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)),
            1'($urandom_range(1)), 4'(i));
      cyc();
      chk("t5_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t5_tag_out", {28'd0, bus.tag_out}, i & 32'hF);
    end
    bus.in_valid = 1'b0;
    repeat (2) cyc();

    // reset mid-stream with both entries occupied
    bus.out_ready = 1'b0;
    drive(2'd0, 4'd9, 4'd9, 1'b1, 4'hA);
    cyc();
    drive(2'd1, 4'd1, 4'd4, 1'b1, 4'hB);
    cyc();
    bus.in_valid = 1'b0;
    chk("t6_pre_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t6_pre_flags_reg", {28'd0, bus.flags_reg}, 32'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_flags_reg", {28'd0, bus.flags_reg}, 32'd0);
    chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    rst_n = 1'b1;

    // traffic after reset: asr keeps the cleared C/V
    bus.out_ready = 1'b1;
    drive(2'd3, 4'h8, 4'h0, 1'b1, 4'hC);
    cyc();
    bus.in_valid = 1'b0;
    chk("t7_result", {28'd0, bus.result}, 32'hC);
    chk("t7_flags_out", {28'd0, bus.flags_out}, 32'b1000);
    repeat (3) cyc();
    chk("final_drain", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
